// File: rtl/rr_counter_scheduler.sv
// Round-robin owner of one shared up-counter: grant 1 cycle after REQ, count 0..LEN, DONE/ABORT pulse on release.
// Latency: GNT one cycle after REQ is seen idle; PAUSE stalls Q but holds the grant, REQ drop aborts.
module rr_counter_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic               C,
  input  logic               CLR,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ*W-1:0] LEN,
  input  logic               PAUSE,
  output logic [N_REQ-1:0]   GNT,
  output logic [W-1:0]       Q,
  output logic               BUSY,
  output logic [N_REQ-1:0]   DONE,
  output logic [N_REQ-1:0]   ABORT
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    own, own_nxt;
  logic [W-1:0]     len_r, len_nxt;
  logic [W-1:0]     q_nxt;
  logic [N_REQ-1:0] gnt_nxt, done_nxt, abort_nxt;
  logic [W-1:0]     len_a [N_REQ];
  logic             win_vld;
  logic [PW-1:0]    win_idx;

  // Search ptr, ptr+1, ... (mod N_REQ) for the first active requester.
  always_comb begin : arb
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      len_a[k] = LEN[k*W +: W];
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      cand = sum[PW-1:0];
      if (!win_vld && REQ[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    own_nxt   = own;
    len_nxt   = len_r;
    q_nxt     = Q;
    gnt_nxt   = GNT;
    done_nxt  = '0;
    abort_nxt = '0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (win_vld) begin
          state_nxt = COUNT;
          gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          own_nxt   = win_idx;
          len_nxt   = len_a[win_idx];
          q_nxt     = '0;
          ptr_nxt   = (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + PW'(1);
        end
      end
      COUNT: begin
        // Terminal count outranks a simultaneous REQ drop.
        if (Q == len_r) begin
          state_nxt     = IDLE;
          gnt_nxt       = '0;
          done_nxt[own] = 1'b1;
        end else if (!REQ[own]) begin
          state_nxt      = IDLE;
          gnt_nxt        = '0;
          abort_nxt[own] = 1'b1;
        end else if (!PAUSE) begin
          q_nxt = Q + W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      len_r <= '0;
      Q     <= '0;
      GNT   <= '0;
      DONE  <= '0;
      ABORT <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      own   <= own_nxt;
      len_r <= len_nxt;
      Q     <= q_nxt;
      GNT   <= gnt_nxt;
      DONE  <= done_nxt;
      ABORT <= abort_nxt;
    end
  end

  assign BUSY = |GNT;

endmodule

// File: tb/tb_rr_counter_scheduler.sv
// Directed bench for rr_counter_scheduler with hand-computed expectations.
module tb_rr_counter_scheduler;

  localparam int N_REQ = 4;
  localparam int W     = 4;

  logic               C = 1'b0;
  logic               CLR;
  logic [N_REQ-1:0]   REQ;
  logic [N_REQ*W-1:0] LEN;
  logic               PAUSE;
  logic [N_REQ-1:0]   GNT;
  logic [W-1:0]       Q;
  logic               BUSY;
  logic [N_REQ-1:0]   DONE;
  logic [N_REQ-1:0]   ABORT;

  int n_chk = 0;
  int n_err = 0;

  rr_counter_scheduler #(.N_REQ(N_REQ), .W(W)) dut (
    .C(C), .CLR(CLR), .REQ(REQ), .LEN(LEN), .PAUSE(PAUSE),
    .GNT(GNT), .Q(Q), .BUSY(BUSY), .DONE(DONE), .ABORT(ABORT)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s obs=%0h want=%0h", tag, obs, want);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic set_len(input int i, input logic [W-1:0] v);
    LEN[i*W +: W] = v;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_gnt"},   GNT,   0);
    check({tag, "_busy"},  BUSY,  0);
  endtask

  int q_exp [8] = '{0, 1, 2, 2, 2, 2, 3, 4};

  initial begin
    CLR = 1'b1; REQ = '0; LEN = '0; PAUSE = 1'b0;
    step();
    step();
    check("rst_gnt", GNT, 0);
    check("rst_q", Q, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_abort", ABORT, 0);
    CLR = 1'b0;
    step();
    chk_idle("idle_noreq");

    // 1: single requester, LEN=3
    REQ = 4'b0001; set_len(0, 3);
    step();
    for (int k = 0; k < 4; k++) begin
      check("t1_gnt", GNT, 4'b0001);
      check("t1_q", Q, k);
      check("t1_busy", BUSY, 1);
      check("t1_done_lo", DONE, 0);
      step();
    end
    check("t1_done", DONE, 4'b0001);
    check("t1_qhold", Q, 3);
    chk_idle("t1_end");
    REQ = '0;
    step();
    check("t1_done_pulse", DONE, 0);

    // 2: all requesting, LEN=1 each, from ptr=0
    CLR = 1'b1; step(); CLR = 1'b0;
    REQ = 4'b1111; LEN = {4'd1, 4'd1, 4'd1, 4'd1};
    step();
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (g % 4);
      check("t2_gnt0", GNT, oh);
      check("t2_q0", Q, 0);
      step();
      check("t2_gnt1", GNT, oh);
      check("t2_q1", Q, 1);
      step();
      check("t2_gap", GNT, 0);
      check("t2_done", DONE, oh);
      if (g == 4) REQ = '0;
      step();
    end
    chk_idle("t2_end");

    // 3: abort at Q=2 (ptr is 1, only REQ0 active)
    REQ = 4'b0001; set_len(0, 5);
    step();
    check("t3_gnt", GNT, 4'b0001);
    step(); step();
    check("t3_q2", Q, 2);
    REQ = '0;
    step();
    check("t3_abort", ABORT, 4'b0001);
    check("t3_nodone", DONE, 0);
    check("t3_qhold", Q, 2);
    chk_idle("t3");
    step();
    check("t3_abort_pulse", ABORT, 0);

    // 4: pause at Q=2 for 3 cycles; LEN change mid-count must be ignored
    REQ = 4'b0010; set_len(1, 4);
    step();
    for (int i = 0; i < 8; i++) begin
      check("t4_gnt", GNT, 4'b0010);
      check("t4_q", Q, q_exp[i]);
      check("t4_done_lo", DONE, 0);
      if (i == 1) set_len(1, 1);
      PAUSE = (i >= 2 && i <= 4);
      step();
    end
    check("t4_done", DONE, 4'b0010);
    check("t4_gnt_off", GNT, 0);
    REQ = '0;
    step();

    // 5: LEN=0 with REQ dropped in the same terminal cycle -> DONE wins
    REQ = 4'b0100; set_len(2, 0);
    step();
    check("t5_gnt", GNT, 4'b0100);
    check("t5_q", Q, 0);
    REQ = '0;
    step();
    check("t5_done", DONE, 4'b0100);
    check("t5_noabort", ABORT, 0);
    chk_idle("t5");

    // full range: LEN=15
    REQ = 4'b0001; set_len(0, 15);
    step();
    for (int k = 0; k < 16; k++) begin
      check("full_q", Q, k);
      step();
    end
    check("full_done", DONE, 4'b0001);
    check("full_q15", Q, 15);
    REQ = '0;
    step();

    // 6: CLR mid-count resets pointer; REQ1 grant leaves ptr=2
    REQ = 4'b0010; set_len(1, 7);
    step();
    check("t6_gnt", GNT, 4'b0010);
    step(); step(); step();
    check("t6_q3", Q, 3);
    CLR = 1'b1;
    step();
    check("t6_gnt_clr", GNT, 0);
    check("t6_q_clr", Q, 0);
    check("t6_nodone", DONE, 0);
    check("t6_noabort", ABORT, 0);
    CLR = 1'b0; REQ = 4'b1111;
    step();
    check("t6_ptr0", GNT, 4'b0001);
    REQ = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
